// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// FSM state encoding, forwarding select codes and the forwarding helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Picks the freshest producer of an EX operand. MEM is younger than WB,
    // so it wins. x0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs_e,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_forward_unit.sv
// Purely combinational hazard detection: load-use between EX and ID,
// and the EX-stage operand forwarding selects.
module hazard_forward_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [1:0] result_src_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic       load_use,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b
);

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time, so the ID instruction must wait one cycle.
    always_comb begin
        load_use  = (result_src_e == RESULTSRC_LOAD) && (rd_e != 5'd0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));
        forward_a = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
        forward_b = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: register
// enables/flushes, forwarding selects, data-memory wait FSM with timeout,
// and saturating stall / branch-flush performance counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic [4:0]       Rd_M,
    input  logic             RegWrite_M,
    input  logic             MemReq_M,
    input  logic             dmem_ready,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_W,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;

    logic       load_use;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       mem_stall;

    logic take_stall;
    logic take_branch;
    logic take_lu;
    logic in_error;

    hazard_forward_unit u_hazard (
        .rs1_d        (Rs1_D),
        .rs2_d        (Rs2_D),
        .rs1_e        (Rs1_E),
        .rs2_e        (Rs2_E),
        .rd_e         (Rd_E),
        .result_src_e (ResultSrc_E),
        .rd_m         (Rd_M),
        .reg_write_m  (RegWrite_M),
        .rd_w         (Rd_W),
        .reg_write_w  (RegWrite_W),
        .load_use     (load_use),
        .forward_a    (fwd_a),
        .forward_b    (fwd_b)
    );

    assign mem_stall = MemReq_M & ~dmem_ready;

    // Pick exactly one pipeline action for this cycle. Memory stalls beat
    // branches, and a branch discards the ID instruction so a simultaneous
    // load-use hazard is moot. Nothing is asserted while in reset.
    always_comb begin
        take_stall  = 1'b0;
        take_branch = 1'b0;
        take_lu     = 1'b0;
        in_error    = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (mem_stall)     take_stall  = 1'b1;
                    else if (PCSrc_E)  take_branch = 1'b1;
                    else if (load_use) take_lu     = 1'b1;
                end
                MEM_WAIT: begin
                    if (!dmem_ready)   take_stall  = 1'b1;
                    else if (PCSrc_E)  take_branch = 1'b1;
                    else if (load_use) take_lu     = 1'b1;
                end
                ERROR: begin
                    in_error = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Map the chosen action onto the register controls. A flushed register
    // is always enabled so the bubble actually gets written.
    always_comb begin
        pc_en       = ~(take_stall | take_lu | in_error);
        ifid_en     = ~(take_stall | take_lu | in_error);
        ifid_flush  = take_branch;
        idex_en     = ~(take_stall | in_error);
        idex_flush  = take_branch | take_lu;
        exmem_en    = ~(take_stall | in_error);
        memwb_flush = take_stall | in_error;
        ForwardA_E  = rst ? fwd_a : FWD_RF;
        ForwardB_E  = rst ? fwd_b : FWD_RF;
    end

    // Data-memory wait FSM: counts stalled cycles and gives up after
    // MEM_TIMEOUT of them, parking in ERROR until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERROR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters: frozen-PC cycles and accepted branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (take_branch && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RISC-V pipeline. It generates the enable and flush controls for the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also generates the EX-stage forwarding selects and runs a data-memory wait FSM with timeout. Two saturating performance counters record stall cycles and branch flushes.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT before a memory-timeout error is declared (>=2)
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
Rs1_D  in  5  rs1 of the instruction in ID
Rs2_D  in  5  rs2 of the instruction in ID
Rs1_E  in  5  rs1 of the instruction in EX
Rs2_E  in  5  rs2 of the instruction in EX
Rd_E  in  5  destination register in EX
ResultSrc_E  in  2  result select in EX; 2'b01 = load
PCSrc_E  in  1  taken branch or jump resolved in EX
Rd_M  in  5  destination register in MEM
RegWrite_M  in  1  MEM instruction writes the register file
MemReq_M  in  1  MEM instruction is a load or store
dmem_ready  in  1  data memory completes the access this cycle
Rd_W  in  5  destination register in WB
RegWrite_W  in  1  WB instruction writes the register file
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID flush
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX flush
exmem_en  out  1  EX/MEM enable
memwb_flush  out  1  MEM/WB flush (inserts a bubble)
ForwardA_E  out  2  00 = RF, 01 = WB result, 10 = MEM ALU result
ForwardB_E  out  2  same encoding, for operand B
mem_err  out  1  registered one-cycle pulse on memory timeout
stall_cnt  out  CNT_W  cycles in which pc_en = 0, saturating
flush_cnt  out  CNT_W  accepted branch flushes, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset: state RUN, wait_cnt 0, counters 0, mem_err 0.
- While rst = 0, combinational outputs are: all enables 1, all flushes 0, forwarding selects 00.
- mem_stall = MemReq_M & ~dmem_ready.
- load_use = (ResultSrc_E == 01) & (Rd_E != 0) & (Rd_E == Rs1_D | Rd_E == Rs2_D).
- Default outputs (RUN, no hazard): all enables 1, all flushes 0.
- RUN, priority mem_stall > PCSrc_E > load_use:
  - mem_stall: pc_en, ifid_en, idex_en and exmem_en = 0; memwb_flush = 1; next state MEM_WAIT; wait_cnt <= 1.
  - PCSrc_E: ifid_flush = 1 and idex_flush = 1, enables stay 1. A load_use hazard in the same cycle is ignored because the ID instruction is discarded. flush_cnt increments.
  - load_use: pc_en = 0, ifid_en = 0, idex_flush = 1. The stall lasts exactly one cycle.
- MEM_WAIT:
  - dmem_ready = 0: same outputs as mem_stall; wait_cnt increments.
  - dmem_ready = 1: evaluate exactly as in RUN, treating mem_stall as 0; next state RUN; wait_cnt <= 0.
  - dmem_ready = 0 and wait_cnt == MEM_TIMEOUT-1: next state ERROR; mem_err = 1 on the following cycle only.
- ERROR: all enables 0, memwb_flush = 1, no other flush. Stays in ERROR until rst. dmem_ready is ignored.
- Forwarding (combinational, in all states):
  - ForwardA_E = 10 if RegWrite_M & Rd_M != 0 & Rd_M == Rs1_E.
  - Otherwise 01 if RegWrite_W & Rd_W != 0 & Rd_W == Rs1_E.
  - Otherwise 00. MEM has priority over WB. ForwardB_E uses Rs2_E in the same way.
- A flush and en = 0 are never asserted on the same register in the same cycle.
- Counters:
  - stall_cnt increments in every cycle with pc_en = 0, including MEM_WAIT and ERROR.
  - Both counters hold at all-ones once saturated.
- Reset asserted mid-MEM_WAIT or in ERROR returns the block to RUN asynchronously and clears the counters.

Decomposition:
- Shared package pipeline_pkg holds:
  - FSM state encoding: RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2.
  - Forward select constants: FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
  - RESULTSRC_LOAD = 2'b01.
- One sub-module, hazard_forward_unit: the purely combinational load_use detection and forwarding-select logic. The FSM, counters and output muxing stay in pipeline_ctrl.

Test Plan:
- Load-use: ResultSrc_E = 01, Rd_E = 5, Rs1_D = 5 -> pc_en = ifid_en = 0 and idex_flush = 1 for exactly one cycle; stall_cnt = 1.
- Branch plus load-use in the same cycle: PCSrc_E = 1 with the load-use condition also true -> ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt = 1.
- Forwarding with x0 exclusion:
  - Rd_M = Rd_W = Rs1_E = 7, both RegWrite = 1 -> ForwardA_E = 10.
  - Same with Rd_M = 0 -> ForwardA_E = 01.
  - Rs2_E = 0 -> ForwardB_E = 00.
- Memory wait: MemReq_M = 1, dmem_ready low for 3 cycles then high -> 3 stall cycles with memwb_flush = 1, release on the 4th cycle, state RUN; stall_cnt = 3.
- Timeout with MEM_TIMEOUT = 4: dmem_ready held low -> ERROR after 4 stall cycles, a single mem_err pulse, all enables held 0. Asserting rst = 0 then returns the block to RUN with counters at 0.
- Saturation with CNT_W = 4: hold ERROR for 20 cycles -> stall_cnt = 15 and holds at 15.
